// File: rtl/bt_air_pkg.sv
// -----------------------------------------------------------------------------
// bt_air_pkg
// Shared definitions for the bt_air_channel air-interface model:
//   rx_state_e  - per-receiver state (settle after hop, own transmit, listen)
//   LFSR_POLY   - Galois taps for x^16+x^14+x^13+x^11+1 (right-shift form)
//   LFSR_SEED   - reset / zero-seed replacement value for the error LFSR
//   MAX_NDEV    - largest supported number of attached devices
//   CNT_W       - width of each per-receiver collision counter
// -----------------------------------------------------------------------------
package bt_air_pkg;

    typedef enum logic [1:0] {
        RX_SETTLE = 2'd0,
        RX_TX     = 2'd1,
        RX_LISTEN = 2'd2
    } rx_state_e;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int unsigned MAX_NDEV  = 8;
    localparam int unsigned CNT_W     = 16;

endpackage

// File: rtl/bt_air_rx.sv
// -----------------------------------------------------------------------------
// bt_air_rx
// One receiver of the air channel: hop-settle state machine, channel
// resolution against all other devices, DELAY-stage output delay line and a
// saturating collision counter.
// Parameters: NDEV, FK_W, DELAY (extra stages), SETTLE (blank cycles), IDX
// (which device this receiver belongs to).
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_txbit, i_txen     transmit bit / on-air flag of every device
//   i_fk                hop channel of every device, device j at [j*FK_W +: FK_W]
//   i_cnt_clr_p         clear pulse for the collision counter
//   o_rxbit, o_rxvalid  received bit and clean-single-source flag (delayed)
//   o_collision         two or more sources heard (delayed)
//   o_coll_cnt          saturating collision counter
// -----------------------------------------------------------------------------
module bt_air_rx
    import bt_air_pkg::*;
#(
    parameter int unsigned NDEV   = 2,
    parameter int unsigned FK_W   = 7,
    parameter int unsigned DELAY  = 0,
    parameter int unsigned SETTLE = 6,
    parameter int unsigned IDX    = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NDEV-1:0]        i_txbit,
    input  logic [NDEV-1:0]        i_txen,
    input  logic [NDEV*FK_W-1:0]   i_fk,
    input  logic                   i_cnt_clr_p,
    output logic                   o_rxbit,
    output logic                   o_rxvalid,
    output logic                   o_collision,
    output logic [CNT_W-1:0]       o_coll_cnt
);

    localparam logic [5:0] SETTLE_LD = 6'(SETTLE - 1);

    rx_state_e         r_state, w_state_nxt;
    logic [5:0]        r_settle_cnt, w_settle_cnt_nxt;
    logic [FK_W-1:0]   r_fk;
    logic [FK_W-1:0]   w_fk_own;
    logic              w_fk_chg;
    logic              w_heard_one, w_heard_many, w_src_bit;
    logic              w_res_bit, w_res_valid, w_res_coll;
    logic [DELAY:0]    r_dly_bit, r_dly_valid, r_dly_coll;
    logic [CNT_W-1:0]  r_coll_cnt;

    assign w_fk_own = i_fk[IDX*FK_W +: FK_W];
    assign w_fk_chg = (w_fk_own != r_fk);

    // Count transmitters (other than ourselves) on our live hop channel.
    always_comb begin
        w_heard_one  = 1'b0;
        w_heard_many = 1'b0;
        w_src_bit    = 1'b0;
        for (int unsigned j = 0; j < NDEV; j++) begin
            if (j != IDX && i_txen[j] && i_fk[j*FK_W +: FK_W] == w_fk_own) begin
                if (w_heard_one) begin
                    w_heard_many = 1'b1;
                end
                w_heard_one = 1'b1;
                w_src_bit   = i_txbit[j];
            end
        end
    end

    always_comb begin
        w_res_bit   = 1'b0;
        w_res_valid = 1'b0;
        w_res_coll  = 1'b0;
        if (r_state == RX_LISTEN) begin
            if (w_heard_many) begin
                w_res_coll = 1'b1;
            end else if (w_heard_one) begin
                w_res_valid = 1'b1;
                w_res_bit   = w_src_bit;
            end
        end
    end

    // A hop change pre-empts everything; the state register only sees it one
    // cycle later, so the change cycle itself still resolves on the new hop.
    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        if (w_fk_chg) begin
            w_state_nxt      = RX_SETTLE;
            w_settle_cnt_nxt = SETTLE_LD;
        end else begin
            case (r_state)
                RX_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        w_state_nxt = i_txen[IDX] ? RX_TX : RX_LISTEN;
                    end else begin
                        w_settle_cnt_nxt = r_settle_cnt - 6'd1;
                    end
                end
                RX_TX: begin
                    if (!i_txen[IDX]) begin
                        w_state_nxt = RX_LISTEN;
                    end
                end
                RX_LISTEN: begin
                    if (i_txen[IDX]) begin
                        w_state_nxt = RX_TX;
                    end
                end
                default: begin
                    w_state_nxt      = RX_SETTLE;
                    w_settle_cnt_nxt = SETTLE_LD;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= RX_SETTLE;
            r_settle_cnt <= SETTLE_LD;
            r_fk         <= '0;
            r_coll_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_fk         <= w_fk_own;
            if (i_cnt_clr_p) begin
                r_coll_cnt <= '0;
            end else if (w_res_coll && r_coll_cnt != '1) begin
                r_coll_cnt <= r_coll_cnt + 1'b1;
            end
        end
    end

    // Stage 0 is the resolution register; stages 1..DELAY are pure delay.
    if (DELAY == 0) begin : g_nodly
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_dly_bit   <= '0;
                r_dly_valid <= '0;
                r_dly_coll  <= '0;
            end else begin
                r_dly_bit   <= w_res_bit;
                r_dly_valid <= w_res_valid;
                r_dly_coll  <= w_res_coll;
            end
        end
    end else begin : g_dly
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_dly_bit   <= '0;
                r_dly_valid <= '0;
                r_dly_coll  <= '0;
            end else begin
                r_dly_bit   <= {r_dly_bit[DELAY-1:0], w_res_bit};
                r_dly_valid <= {r_dly_valid[DELAY-1:0], w_res_valid};
                r_dly_coll  <= {r_dly_coll[DELAY-1:0], w_res_coll};
            end
        end
    end

    assign o_rxbit     = r_dly_bit[DELAY];
    assign o_rxvalid   = r_dly_valid[DELAY];
    assign o_collision = r_dly_coll[DELAY];
    assign o_coll_cnt  = r_coll_cnt;

endmodule

// File: rtl/bt_air_channel.sv
// -----------------------------------------------------------------------------
// bt_air_channel
// Cycle-based air-interface model connecting NDEV baseband instances. Each
// receiver gets the bit of the single other device transmitting on its hop
// channel, with half-duplex gating, collision detection/counting, hop-settle
// blanking and a configurable propagation delay.
// Optional feature macro: AIR_ERRINJ_EN (LFSR-driven bit-error injection).
// Parameters: NDEV (2..8), FK_W, DELAY (0..15), SETTLE (1..63).
// Ports:
//   clk_6M, rstz          clock, asynchronous active-low reset
//   txbit, txen           per-device transmit bit / on-air flag
//   fk                    per-device hop channel, device i at [i*FK_W +: FK_W]
//   regi_cnt_clr_p        clears all collision counters
//   regi_ber_thresh       error threshold (0 = no errors)
//   regi_err_seed         LFSR seed, loaded by regi_err_load_p
//   rxbit, rxvalid        per-device received bit / clean single source
//   collision             per-device two-or-more-sources flag
//   coll_cnt              per-device 16-bit saturating collision counters
// -----------------------------------------------------------------------------
module bt_air_channel
    import bt_air_pkg::*;
#(
    parameter int unsigned NDEV   = 2,
    parameter int unsigned FK_W   = 7,
    parameter int unsigned DELAY  = 0,
    parameter int unsigned SETTLE = 6
) (
    input  logic                   clk_6M,
    input  logic                   rstz,
    input  logic [NDEV-1:0]        txbit,
    input  logic [NDEV-1:0]        txen,
    input  logic [NDEV*FK_W-1:0]   fk,
    input  logic                   regi_cnt_clr_p,
    input  logic [7:0]             regi_ber_thresh,
    input  logic [15:0]            regi_err_seed,
    input  logic                   regi_err_load_p,
    output logic [NDEV-1:0]        rxbit,
    output logic [NDEV-1:0]        rxvalid,
    output logic [NDEV-1:0]        collision,
    output logic [NDEV*CNT_W-1:0]  coll_cnt
);

    logic [NDEV-1:0] w_rxbit_raw;
    logic [NDEV-1:0] w_flip;

`ifdef AIR_ERRINJ_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_lfsr <= LFSR_SEED;
        end else if (regi_err_load_p) begin
            r_lfsr <= (regi_err_seed == '0) ? LFSR_SEED : regi_err_seed;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);
        end
    end

    // Each receiver sees a differently scrambled view of the same LFSR byte.
    for (genvar g = 0; g < NDEV; g++) begin : g_flip
        localparam logic [7:0] RX_MASK = 8'(8'h35 * g);
        assign w_flip[g] = rxvalid[g] && ((r_lfsr[7:0] ^ RX_MASK) < regi_ber_thresh);
    end
`else
    logic w_unused_errinj;
    assign w_unused_errinj = ^{regi_ber_thresh, regi_err_seed, regi_err_load_p};
    assign w_flip          = '0;
`endif

    for (genvar g = 0; g < NDEV; g++) begin : g_rx
        bt_air_rx #(
            .NDEV   (NDEV),
            .FK_W   (FK_W),
            .DELAY  (DELAY),
            .SETTLE (SETTLE),
            .IDX    (g)
        ) u_rx (
            .i_clk       (clk_6M),
            .i_rst_n     (rstz),
            .i_txbit     (txbit),
            .i_txen      (txen),
            .i_fk        (fk),
            .i_cnt_clr_p (regi_cnt_clr_p),
            .o_rxbit     (w_rxbit_raw[g]),
            .o_rxvalid   (rxvalid[g]),
            .o_collision (collision[g]),
            .o_coll_cnt  (coll_cnt[g*CNT_W +: CNT_W])
        );
    end

    assign rxbit = w_rxbit_raw ^ w_flip;

endmodule

// File: tb/tb_bt_air_channel.sv
`timescale 1ns/1ps
module tb_bt_air_channel;

    localparam int SETTLE = 6;

    logic        clk = 1'b0;
    logic        rstz;
    logic [2:0]  txbit, txen;
    logic [6:0]  fk_in [3];
    logic        clr, load;
    logic [7:0]  thresh;
    logic [15:0] seed;

    logic [20:0] fk_a;
    logic [13:0] fk_b;
    assign fk_a = {fk_in[2], fk_in[1], fk_in[0]};
    assign fk_b = {fk_in[1], fk_in[0]};

    logic [2:0]  a_rxbit, a_rxvalid, a_coll;
    logic [47:0] a_cnt;
    logic [1:0]  b_rxbit, b_rxvalid, b_coll;
    logic [31:0] b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // DUT A: 3 devices, no extra delay. DUT B: devices 0/1 only, DELAY=3.
    bt_air_channel #(.NDEV(3), .FK_W(7), .DELAY(0), .SETTLE(SETTLE)) u_dut_a (
        .clk_6M(clk), .rstz(rstz), .txbit(txbit), .txen(txen), .fk(fk_a),
        .regi_cnt_clr_p(clr), .regi_ber_thresh(thresh), .regi_err_seed(seed),
        .regi_err_load_p(load), .rxbit(a_rxbit), .rxvalid(a_rxvalid),
        .collision(a_coll), .coll_cnt(a_cnt)
    );

    bt_air_channel #(.NDEV(2), .FK_W(7), .DELAY(3), .SETTLE(SETTLE)) u_dut_b (
        .clk_6M(clk), .rstz(rstz), .txbit(txbit[1:0]), .txen(txen[1:0]), .fk(fk_b),
        .regi_cnt_clr_p(clr), .regi_ber_thresh(thresh), .regi_err_seed(seed),
        .regi_err_load_p(load), .rxbit(b_rxbit), .rxvalid(b_rxvalid),
        .collision(b_coll), .coll_cnt(b_cnt)
    );

    // ---------------- reference model ----------------
    // Per receiver: remaining blanked resolutions, whether it is its own
    // transmitter, last seen hop, counter, and a history of resolved triples
    // {coll, valid, bit} (index 0 = newest).
    int          m_blank [2][3];
    bit          m_tx    [2][3];
    logic [6:0]  m_fk    [2][3];
    int          m_cnt   [2][3];
    logic [2:0]  m_hist  [2][3][16];
    logic [15:0] m_lfsr;

    function automatic int ndev_of(int d);
        return (d == 0) ? 3 : 2;
    endfunction

    function automatic int dly_of(int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) begin
                m_blank[d][i] = SETTLE;
                m_tx[d][i]    = 1'b0;
                m_fk[d][i]    = '0;
                m_cnt[d][i]   = 0;
                for (int k = 0; k < 16; k++) m_hist[d][i][k] = 3'b000;
            end
        m_lfsr = 16'hACE1;
    endfunction

    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < ndev_of(d); i++) begin
                int         cands;
                logic       b;
                logic [2:0] res;
                cands = 0;
                b     = 1'b0;
                res   = 3'b000;
                if (m_blank[d][i] == 0 && !m_tx[d][i]) begin
                    for (int j = 0; j < ndev_of(d); j++)
                        if (j != i && txen[j] && fk_in[j] == fk_in[i]) begin
                            cands++;
                            b = txbit[j];
                        end
                    if (cands == 1)      res = {2'b01, b};
                    else if (cands >= 2) res = 3'b100;
                end
                if (clr)                                 m_cnt[d][i] = 0;
                else if (res[2] && m_cnt[d][i] < 65535)  m_cnt[d][i]++;
                for (int k = 15; k > 0; k--) m_hist[d][i][k] = m_hist[d][i][k-1];
                m_hist[d][i][0] = res;
                if (fk_in[i] != m_fk[d][i]) begin
                    m_fk[d][i]    = fk_in[i];
                    m_blank[d][i] = SETTLE;
                    m_tx[d][i]    = 1'b0;
                end else begin
                    if (m_blank[d][i] > 0) m_blank[d][i]--;
                    if (m_blank[d][i] == 0) m_tx[d][i] = txen[i];
                end
            end
        end
`ifdef AIR_ERRINJ_EN
        if (load)            m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
        else if (m_lfsr[0])  m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
        else                 m_lfsr = m_lfsr >> 1;
`endif
    endfunction

    // {cnt[15:0], coll, valid, bit}
    function automatic logic [18:0] model_out(int d, int i);
        logic [2:0] p;
        logic       b;
        p = m_hist[d][i][dly_of(d)];
        b = p[0];
`ifdef AIR_ERRINJ_EN
        if (p[1] && ((m_lfsr[7:0] ^ 8'(8'h35 * i)) < thresh)) b = ~b;
`endif
        return {16'(m_cnt[d][i]), p[2], p[1], b};
    endfunction

    function automatic logic [18:0] dut_out(int d, int i);
        if (d == 0) return {a_cnt[i*16 +: 16], a_coll[i], a_rxvalid[i], a_rxbit[i]};
        return {b_cnt[i*16 +: 16], b_coll[i], b_rxvalid[i], b_rxbit[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < ndev_of(d); i++)
                check($sformatf("model_dut%0d_rx%0d", d, i), 32'(dut_out(d, i)), 32'(model_out(d, i)));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // ---------------- directed vector table (DUT A) ----------------
    typedef struct {
        logic [2:0]  txen;
        logic [2:0]  txbit;
        logic [6:0]  fk1;
        logic        clr;
        logic [2:0]  e_bit;
        logic [2:0]  e_valid;
        logic [2:0]  e_coll;
        logic [15:0] e_cnt2;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int zeros, found, lat, any_out;

        // dev0 sends 1010 on fk 20, then dev1 joins (collision at dev2),
        // clear coincident with collision, dev1 alone, dev1 hops away.
        vecs[0]  = '{3'b001, 3'b001, 7'd20, 1'b0, 3'b110, 3'b110, 3'b000, 16'd0};
        vecs[1]  = '{3'b001, 3'b000, 7'd20, 1'b0, 3'b000, 3'b110, 3'b000, 16'd0};
        vecs[2]  = '{3'b001, 3'b001, 7'd20, 1'b0, 3'b110, 3'b110, 3'b000, 16'd0};
        vecs[3]  = '{3'b001, 3'b000, 7'd20, 1'b0, 3'b000, 3'b110, 3'b000, 16'd0};
        vecs[4]  = '{3'b011, 3'b011, 7'd20, 1'b0, 3'b010, 3'b010, 3'b100, 16'd1};
        vecs[5]  = '{3'b011, 3'b011, 7'd20, 1'b0, 3'b000, 3'b000, 3'b100, 16'd2};
        vecs[6]  = '{3'b011, 3'b011, 7'd20, 1'b1, 3'b000, 3'b000, 3'b100, 16'd0};
        vecs[7]  = '{3'b011, 3'b011, 7'd20, 1'b0, 3'b000, 3'b000, 3'b100, 16'd1};
        vecs[8]  = '{3'b010, 3'b010, 7'd20, 1'b0, 3'b100, 3'b100, 3'b000, 16'd1};
        vecs[9]  = '{3'b010, 3'b000, 7'd20, 1'b0, 3'b000, 3'b101, 3'b000, 16'd1};
        vecs[10] = '{3'b010, 3'b010, 7'd9,  1'b0, 3'b000, 3'b000, 3'b000, 16'd1};

        txbit = '0; txen = '0; clr = 1'b0; load = 1'b0; thresh = 8'd0; seed = 16'h1234;
        for (int k = 0; k < 3; k++) fk_in[k] = 7'd0;
        rstz = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_rxvalid", {29'd0, a_rxvalid}, 32'd0);
        check("reset_cnt2", {16'd0, a_cnt[47:32]}, 32'd0);
        #3 rstz = 1'b1;

        // Settle everyone onto fk 20.
        for (int k = 0; k < 3; k++) fk_in[k] = 7'd20;
        repeat (10) tick();

        for (int v = 0; v < 11; v++) begin
            txen = vecs[v].txen; txbit = vecs[v].txbit;
            fk_in[1] = vecs[v].fk1; clr = vecs[v].clr;
            tick();
            clr = 1'b0;
            check($sformatf("vec%0d_rxbit", v),   {29'd0, a_rxbit},   {29'd0, vecs[v].e_bit});
            check($sformatf("vec%0d_rxvalid", v), {29'd0, a_rxvalid}, {29'd0, vecs[v].e_valid});
            check($sformatf("vec%0d_coll", v),    {29'd0, a_coll},    {29'd0, vecs[v].e_coll});
            check($sformatf("vec%0d_cnt2", v),    {16'd0, a_cnt[47:32]}, {16'd0, vecs[v].e_cnt2});
        end

        // Hop settle: dev0 transmits on 9, dev1 hops 5 -> 9.
        txen = 3'b001; fk_in[0] = 7'd9; fk_in[1] = 7'd5; fk_in[2] = 7'd30;
        repeat (12) begin txbit = 3'($urandom); tick(); end
        check("settle_pre_invalid", {31'd0, a_rxvalid[1]}, 32'd0);
        fk_in[1] = 7'd9;
        tick();
        check("settle_change_cycle_valid", {31'd0, a_rxvalid[1]}, 32'd1);
        zeros = 0; found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            txbit = 3'($urandom);
            tick();
            if (a_rxvalid[1]) found = 1;
            else zeros++;
        end
        check("settle_blank_len", 32'(zeros), 32'(SETTLE));
        check("settle_recovered", 32'(found), 32'd1);
        check("settle_first_bit", {31'd0, a_rxbit[1]}, {31'd0, txbit[0]});

        // Latency: single 1 from dev0, dev1 receives on 9.
        txbit = 3'b000;
        repeat (6) tick();
        txbit = 3'b001;
        tick();
        check("latency_a_1cycle", {31'd0, a_rxbit[1]}, 32'd1);
        lat = 1;
        txbit = 3'b000;
        while (b_rxbit[1] !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        check("latency_b_4cycle", 32'(lat), 32'd4);

        // Reset mid-stream with DUT B's delay line full.
        repeat (3) begin txbit = 3'($urandom); tick(); end
        #3 rstz = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_async_b", {28'd0, b_rxvalid, b_rxbit}, 32'd0);
        @(posedge clk);
        #1;
        check_all();
        #3 rstz = 1'b1;
        any_out = 0;
        repeat (6) begin
            txbit = 3'($urandom);
            tick();
            if ((|b_rxbit) || (|b_rxvalid) || (|a_rxbit) || (|a_rxvalid)) any_out++;
        end
        check("rst_no_stale", 32'(any_out), 32'd0);

        // Counter saturation: dev0+dev1 on 5, dev2 listening on 5.
        for (int k = 0; k < 3; k++) fk_in[k] = 7'd5;
        txen = 3'b011;
        repeat (10) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sat_clr", {16'd0, a_cnt[47:32]}, 32'd0);
        repeat (65534) begin txbit = 3'($urandom); tick(); end
        check("sat_fffe", {16'd0, a_cnt[47:32]}, 32'h0000FFFE);
        check("sat_coll_flag", {31'd0, a_coll[2]}, 32'd1);
        tick();
        check("sat_ffff", {16'd0, a_cnt[47:32]}, 32'h0000FFFF);
        tick();
        check("sat_hold", {16'd0, a_cnt[47:32]}, 32'h0000FFFF);

        // Randomized traffic on two close hops against the model.
        for (int c = 0; c < 2000; c++) begin
            txen  = 3'($urandom);
            txbit = 3'($urandom);
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 15) == 0) fk_in[k] = 7'(3 + $urandom_range(0, 1));
            clr    = ($urandom_range(0, 31) == 0);
            load   = ($urandom_range(0, 63) == 0);
            seed   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            thresh = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bt_air_channel.md
# bt_air_channel

Cycle-based, synthesizable air-interface model for multi-device link simulation and FPGA co-emulation. Connects NDEV baseband instances (txbit, fk per device) and delivers each receiver the bit from the single other device transmitting on the same hop channel. Adds what a plain fk-equality mux lacks:
- transmit enable and half-duplex gating
- collision detection and counting
- hop-settle blanking
- configurable propagation delay
- optional LFSR bit-error injection

## Interface
Parameters:
- NDEV, 2: number of attached devices, 2..8
- FK_W, 7: hop channel index width
- DELAY, 0: extra propagation pipeline stages, 0..15
- SETTLE, 6: blanked cycles after a receiver's fk changes, 1..63

Ports:
- clk_6M  in  1  system clock, shared by all devices
- rstz  in  1  asynchronous active-low reset
- txbit  in  NDEV  per-device transmit bit
- txen  in  NDEV  per-device transmitter on-air
- fk  in  NDEV*FK_W  per-device hop channel, device i at [i*FK_W +: FK_W]
- regi_cnt_clr_p  in  1  one-cycle pulse, clears all collision counters
- regi_ber_thresh  in  8  error threshold; 0 = no errors (only with AIR_ERRINJ_EN)
- regi_err_seed  in  16  LFSR seed
- regi_err_load_p  in  1  one-cycle pulse, loads regi_err_seed
- rxbit  out  NDEV  per-device received bit
- rxvalid  out  NDEV  rxbit carries a clean single-source bit
- collision  out  NDEV  two or more sources heard this cycle
- coll_cnt  out  NDEV*16  per-receiver saturating collision counters

## Operation
- Per-receiver state machine, each clk_6M cycle:
  - RX_SETTLE: entered on reset and whenever fk[i] differs from its registered copy. Counter loads SETTLE-1 and counts to 0, then goes to RX_LISTEN. An fk change during settle reloads the counter.
  - RX_TX: entered when txen[i]=1 (highest priority after settle). Returns to RX_LISTEN when txen[i]=0.
  - RX_LISTEN: resolves the channel.
- Resolution, RX_LISTEN only: candidates are devices j≠i with txen[j]=1 and fk[j]==fk[i].
  - 0 candidates: valid=0, bit=0, coll=0.
  - 1 candidate: valid=1, bit=txbit[j], coll=0.
  - ≥2 candidates: valid=0, bit=0, coll=1.
- Outside RX_LISTEN: valid=0, bit=0, coll=0.
- The resolved triple is registered, then passes through a DELAY-stage shift register to rxbit/rxvalid/collision.
- coll_cnt[i]:
  - increments at the resolution register when coll=1
  - saturates at 16'hFFFF
  - regi_cnt_clr_p has priority over a same-cycle increment; the result is 0.
- An fk change on a transmitting device affects others from the next resolution cycle; no settle is applied to transmitters.

## Timing
- Latency from txbit/txen/fk to rxbit: 1+DELAY cycles.
- After an fk change at edge n, the settle-state comparison is registered. Resolution is blanked for cycles n+1..n+SETTLE and first valid at n+SETTLE+1, observed at the output DELAY+1 cycles later.
- Reset values:
  - rxbit, rxvalid, collision, all pipeline stages: 0
  - coll_cnt: 0
  - state: RX_SETTLE with counter SETTLE-1
  - registered fk: 0
  - LFSR: 16'hACE1
- Reset mid-operation clears pipeline contents immediately; no partial bits emerge afterwards.

## Configuration
- AIR_ERRINJ_EN defined:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, steps every cycle.
  - regi_err_load_p loads regi_err_seed; a seed of 0 is replaced by 16'hACE1.
  - At the final pipeline stage, receiver i inverts rxbit when rxvalid=1 and (lfsr[7:0] ^ (8'h35*i)) < regi_ber_thresh. rxvalid is unchanged.
- AIR_ERRINJ_EN undefined:
  - No LFSR; regi_ber_thresh, regi_err_seed and regi_err_load_p are ignored.
  - rxbit is never inverted.

## Structure
- Shared package bt_air_pkg: rx state enum (RX_SETTLE, RX_TX, RX_LISTEN), LFSR polynomial and default seed constants, max NDEV constant.
- Sub-module bt_air_rx: one receiver (state machine, settle counter, resolution, delay line, counter), instantiated NDEV times via generate.
- LFSR lives in the top.

## Test plan
- NDEV=2, DELAY=0, SETTLE=6: both fk=7'd20, dev0 txen=1 sends 1010, dev1 idle. Expect rxbit[1]=1,0,1,0 with rxvalid[1]=1, 1 cycle later; rxvalid[0]=0.
- NDEV=3: devs 0 and 1 transmit on fk=7'd5, dev2 listens on 5. Expect collision[2]=1 every cycle and coll_cnt[2] counting; a regi_cnt_clr_p coincident with a collision gives coll_cnt[2]=0.
- Dev1 fk changes 5→9 while dev0 transmits on 9. Expect rxvalid[1]=0 for exactly 6 cycles, then valid data.
- DELAY=3: single transmitter. Latency is 4 cycles; assert rstz mid-stream and expect all outputs 0 with no stale bits after release.
- With AIR_ERRINJ_EN: regi_ber_thresh=0 gives zero flips; regi_ber_thresh=255 flips almost all bits. Seed 16'h1234 loaded twice gives identical flip patterns.
- Force coll_cnt to 16'hFFFE, then two collisions. Expect the counter to hold at 16'hFFFF.
